// File: rtl/control_seq_pkg.sv
// Shared types and encodings for the control sequencer: state enum, datapath
// select encodings, RV32 opcode field values and abstract command opcodes.
package control_seq_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StMemWb,
        StWfi,
        StHalted,
        StAbsReg,
        StAbsExec,
        StAbsMem,
        StAbsDone
    } state_e;

    // addr_sel
    localparam logic [1:0] AddrPc   = 2'd0;
    localparam logic [1:0] AddrAlu  = 2'd1;
    // rd_sel
    localparam logic [1:0] RdAlu    = 2'd0;
    localparam logic [1:0] RdMem    = 2'd1;
    localparam logic [1:0] RdPc4    = 2'd2;
    localparam logic [1:0] RdCsr    = 2'd3;
    // alu_insel1
    localparam logic [1:0] Alu1Rs1  = 2'd0;
    localparam logic [1:0] Alu1Pc   = 2'd1;
    localparam logic [1:0] Alu1Zero = 2'd2;
    // alu_insel2
    localparam logic [1:0] Alu2Rs2  = 2'd0;
    localparam logic [1:0] Alu2Imm  = 2'd1;
    localparam logic [1:0] Alu2Four = 2'd2;

    // instr[6:2]
    localparam logic [4:0] OpcLoad    = 5'b00000;
    localparam logic [4:0] OpcMiscMem = 5'b00011;
    localparam logic [4:0] OpcOpImm   = 5'b00100;
    localparam logic [4:0] OpcAuipc   = 5'b00101;
    localparam logic [4:0] OpcStore   = 5'b01000;
    localparam logic [4:0] OpcOp      = 5'b01100;
    localparam logic [4:0] OpcLui     = 5'b01101;
    localparam logic [4:0] OpcBranch  = 5'b11000;
    localparam logic [4:0] OpcJalr    = 5'b11001;
    localparam logic [4:0] OpcJal     = 5'b11011;
    localparam logic [4:0] OpcSystem  = 5'b11100;
    localparam logic [2:0] F3Priv     = 3'b000;

    // Abstract commands (opcode) and flag bits (f3)
    localparam logic [4:0] AbsOpReg   = 5'b00000;
    localparam logic [4:0] AbsOpMem   = 5'b00010;
    localparam int unsigned AbsF3Exec  = 0;  // run one post-exec cycle
    localparam int unsigned AbsF3Write = 1;  // 1: debug -> core, 0: core -> debug
    localparam int unsigned AbsF3Csr   = 2;  // register access targets a CSR

endpackage

// File: rtl/control_seq_timeout.sv
// Memory wait timer: counts enabled cycles, flags the MEM_TIMEOUT-th one.
// MEM_TIMEOUT = 0 disables expiry.
module control_seq_timeout #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned Last = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && en && (cnt_q == CntW'(Last));

endmodule

// File: rtl/control_seq.sv
// Multi-cycle control sequencer for the RV32 core: fetch/decode/execute,
// split memory beats, bounded memory wait, debug halt/resume and abstract
// commands. Optional single-step support with CONTROL_SEQ__SINGLE_STEP_EN.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int unsigned MAX_BEATS   = 2,
    parameter int unsigned ABS_BURST_W = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    localparam int unsigned BeatW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int unsigned NeedW = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             opcode,
    input  logic [2:0]             f3,
    input  logic [NeedW-1:0]       beats_needed,
    input  logic                   mem_complete,
    input  logic                   exception,
    input  logic                   interrupt_pending,
    input  logic                   halt_req,
    input  logic                   resume_req,
    input  logic                   abstract,
    input  logic [ABS_BURST_W-1:0] abs_count,
`ifdef CONTROL_SEQ__SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [BeatW-1:0]       beat_idx,
    output logic                   write_ir,
    output logic                   write_pc,
    output logic                   write_pc_ex,
    output logic                   write_rd,
    output logic                   write_csr,
    output logic [1:0]             addr_sel,
    output logic [1:0]             rd_sel,
    output logic [1:0]             alu_insel1,
    output logic [1:0]             alu_insel2,
    output logic                   abs_addr_inc,
    output logic                   abstract_write,
    output logic                   abstract_done,
    output logic                   bus_timeout,
    output logic                   halted,
    output logic                   retire
);

    state_e                 state_q, state_d;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic [ABS_BURST_W-1:0] burst_q, burst_d;
    logic                   store_q, store_d;
    logic                   step_q, step_d;
    logic                   step_in;
    logic                   strobe_raw, tmo_en, tmo_clr, tmo_expired;
    logic                   trap, to_fetch, abs_state, last_beat, too_many;

`ifdef CONTROL_SEQ__SINGLE_STEP_EN
    assign step_in = step;
`else
    assign step_in = 1'b0;
`endif

    // Timer enable comes from state only, so expiry never loops back through outputs.
    assign strobe_raw = rst_n && (state_q inside {StFetch, StMem, StAbsMem});
    assign tmo_en     = strobe_raw && !mem_complete;
    assign tmo_clr    = (state_d != state_q) || mem_complete || tmo_expired;
    assign abs_state  = state_q inside {StHalted, StAbsReg, StAbsExec, StAbsMem, StAbsDone};
    assign last_beat  = (32'(beat_q) + 32'd1) >= 32'(beats_needed);
    assign too_many   = 32'(beats_needed) > MAX_BEATS;
    assign beat_idx   = beat_q;

    control_seq_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    // Next-state and output decode; outputs stay idle while reset is held.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        burst_d        = burst_q;
        store_d        = store_q;
        step_d         = step_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        write_ir       = 1'b0;
        write_pc       = 1'b0;
        write_pc_ex    = 1'b0;
        write_rd       = 1'b0;
        write_csr      = 1'b0;
        addr_sel       = AddrPc;
        rd_sel         = RdAlu;
        alu_insel1     = Alu1Rs1;
        alu_insel2     = Alu2Rs2;
        abs_addr_inc   = 1'b0;
        abstract_write = 1'b0;
        abstract_done  = 1'b0;
        bus_timeout    = 1'b0;
        halted         = 1'b0;
        retire         = 1'b0;
        trap           = 1'b0;
        to_fetch       = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    if (mem_complete) begin
                        write_ir = 1'b1;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    store_d = (opcode == OpcStore);
                    case (opcode)
                        OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcOp, OpcOpImm, OpcBranch,
                        OpcMiscMem: state_d = StExec;
                        OpcLoad, OpcStore: state_d = StMem;
                        // While stepping, WFI executes as a NOP.
                        OpcSystem: state_d = (f3 == F3Priv && !step_q) ? StWfi : StExec;
                        default: trap = 1'b1;  // illegal opcode
                    endcase
                end
                StExec: begin
                    write_pc = 1'b1;
                    retire   = 1'b1;
                    to_fetch = 1'b1;
                    case (opcode)
                        OpcLui: begin
                            alu_insel1 = Alu1Zero;
                            alu_insel2 = Alu2Imm;
                            write_rd   = 1'b1;
                        end
                        OpcAuipc: begin
                            alu_insel1 = Alu1Pc;
                            alu_insel2 = Alu2Imm;
                            write_rd   = 1'b1;
                        end
                        OpcJal: begin
                            alu_insel1 = Alu1Pc;
                            alu_insel2 = Alu2Imm;
                            rd_sel     = RdPc4;
                            write_rd   = 1'b1;
                        end
                        OpcJalr: begin
                            alu_insel2 = Alu2Imm;
                            rd_sel     = RdPc4;
                            write_rd   = 1'b1;
                        end
                        OpcOp: write_rd = 1'b1;
                        OpcOpImm: begin
                            alu_insel2 = Alu2Imm;
                            write_rd   = 1'b1;
                        end
                        OpcBranch: begin
                            alu_insel1 = Alu1Pc;
                            alu_insel2 = Alu2Imm;
                        end
                        OpcSystem: begin
                            if (f3 != F3Priv) begin
                                rd_sel    = RdCsr;
                                write_rd  = 1'b1;
                                write_csr = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    addr_sel   = AddrAlu;
                    alu_insel2 = Alu2Imm;
                    mem_read   = !store_q;
                    mem_write  = store_q;
                    if (too_many) begin
                        trap = 1'b1;  // misaligned beyond bus splitting capability
                    end else if (mem_complete) begin
                        if (last_beat) begin
                            if (store_q) begin
                                write_pc = 1'b1;
                                retire   = 1'b1;
                                to_fetch = 1'b1;
                            end else begin
                                state_d = StMemWb;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                StMemWb: begin
                    rd_sel   = RdMem;
                    write_rd = 1'b1;
                    write_pc = 1'b1;
                    retire   = 1'b1;
                    to_fetch = 1'b1;
                end
                StWfi: begin
                    if (halt_req) begin
                        state_d = StHalted;
                    end else if (interrupt_pending) begin
                        write_pc = 1'b1;
                        retire   = 1'b1;
                        to_fetch = 1'b1;
                    end
                end
                StHalted: begin
                    halted = 1'b1;
                    if (abstract) begin
                        burst_d = abs_count;
                        state_d = (opcode == AbsOpMem) ? StAbsMem : StAbsReg;
                    end else if (resume_req) begin
                        step_d  = step_in;
                        state_d = StFetch;
                    end
                end
                StAbsReg: begin
                    if (f3[AbsF3Write]) begin
                        write_csr = f3[AbsF3Csr];
                        write_rd  = !f3[AbsF3Csr];
                    end else begin
                        rd_sel         = f3[AbsF3Csr] ? RdCsr : RdAlu;
                        abstract_write = 1'b1;
                    end
                    if (f3[AbsF3Exec]) begin
                        state_d = StAbsExec;
                    end else begin
                        abstract_done = 1'b1;
                        state_d       = StHalted;
                    end
                end
                StAbsExec: begin
                    abstract_done = 1'b1;
                    state_d       = StHalted;
                end
                StAbsMem: begin
                    addr_sel  = AddrAlu;
                    mem_read  = !f3[AbsF3Write];
                    mem_write = f3[AbsF3Write];
                    if (tmo_expired) begin
                        bus_timeout = 1'b1;
                        mem_read    = 1'b0;
                        mem_write   = 1'b0;
                        state_d     = StAbsDone;
                    end else if (mem_complete) begin
                        abstract_write = !f3[AbsF3Write];
                        abs_addr_inc   = 1'b1;
                        if (burst_q == '0) begin
                            state_d = StAbsDone;
                        end else begin
                            burst_d = burst_q - 1'b1;
                        end
                    end
                end
                StAbsDone: begin
                    abstract_done = 1'b1;
                    state_d       = StHalted;
                end
                default: state_d = StFetch;
            endcase

            // Timeout outside abstract commands is handled as a trap.
            if (!abs_state && tmo_expired) begin
                bus_timeout = 1'b1;
                mem_read    = 1'b0;
                mem_write   = 1'b0;
                trap        = 1'b1;
            end
            if (!abs_state && exception) begin
                trap = 1'b1;
            end
            if (trap) begin
                write_rd    = 1'b0;
                write_csr   = 1'b0;
                mem_write   = 1'b0;
                write_ir    = 1'b0;
                write_pc    = 1'b0;
                retire      = 1'b0;
                write_pc_ex = 1'b1;
                to_fetch    = 1'b1;
            end
            // Instruction boundary: halt requests and single-step completion land here.
            if (to_fetch) begin
                state_d = (halt_req || step_q) ? StHalted : StFetch;
            end
            if (state_d == StHalted) begin
                step_d = 1'b0;
            end
            if (state_d != StMem) begin
                beat_d = '0;
            end
        end
    end

    // State and counter registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            beat_q  <= '0;
            burst_q <= '0;
            store_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            store_q <= store_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq (MEM_TIMEOUT=5). Define
// CONTROL_SEQ__SINGLE_STEP_EN to also cover single-step.
module tb_control_seq;

    localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, OP = 5'b01100;
    localparam logic [4:0] OPIMM = 5'b00100, SYSTEM = 5'b11100;
    localparam logic [4:0] ABS_REG = 5'b00000, ABS_MEM = 5'b00010;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] opcode;
    logic [2:0] f3;
    logic [1:0] beats_needed;
    logic mem_complete, exception, interrupt_pending, halt_req, resume_req, abstract;
    logic [3:0] abs_count;
`ifdef CONTROL_SEQ__SINGLE_STEP_EN
    logic step;
`endif
    logic mem_read, mem_write, write_ir, write_pc, write_pc_ex, write_rd, write_csr;
    logic [0:0] beat_idx;
    logic [1:0] addr_sel, rd_sel, alu_insel1, alu_insel2;
    logic abs_addr_inc, abstract_write, abstract_done, bus_timeout, halted, retire;

    int total = 0;
    int bad = 0;
    int n_wr, n_inc, n_done, n_ret, n_mw;
    logic seen;

    always #5 clk = ~clk;

    control_seq #(
        .MAX_BEATS  (2),
        .ABS_BURST_W(4),
        .MEM_TIMEOUT(5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opcode           (opcode),
        .f3               (f3),
        .beats_needed     (beats_needed),
        .mem_complete     (mem_complete),
        .exception        (exception),
        .interrupt_pending(interrupt_pending),
        .halt_req         (halt_req),
        .resume_req       (resume_req),
        .abstract         (abstract),
        .abs_count        (abs_count),
`ifdef CONTROL_SEQ__SINGLE_STEP_EN
        .step             (step),
`endif
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .beat_idx         (beat_idx),
        .write_ir         (write_ir),
        .write_pc         (write_pc),
        .write_pc_ex      (write_pc_ex),
        .write_rd         (write_rd),
        .write_csr        (write_csr),
        .addr_sel         (addr_sel),
        .rd_sel           (rd_sel),
        .alu_insel1       (alu_insel1),
        .alu_insel2       (alu_insel2),
        .abs_addr_inc     (abs_addr_inc),
        .abstract_write   (abstract_write),
        .abstract_done    (abstract_done),
        .bus_timeout      (bus_timeout),
        .halted           (halted),
        .retire           (retire)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = LOAD; f3 = 3'b000; beats_needed = 2'd1; mem_complete = 1'b0;
        exception = 1'b0; interrupt_pending = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        abstract = 1'b0; abs_count = 4'd0;
`ifdef CONTROL_SEQ__SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_beat", beat_idx, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_sels", {addr_sel, rd_sel, alu_insel1, alu_insel2}, 0);
        rst_n = 1'b1;
        #1;
        chk("fetch_mem_read", mem_read, 1);
        chk("fetch_addr_pc", addr_sel, 0);

        // Aligned LW, single-cycle memory.
        nxt(); opcode = LOAD; beats_needed = 2'd1; mem_complete = 1'b1; #1;
        chk("lw_write_ir", write_ir, 1);
        nxt(); mem_complete = 1'b0; #1;
        chk("lw_decode_idle", mem_read, 0);
        nxt(); mem_complete = 1'b1; #1;
        chk("lw_mem_read", mem_read, 1);
        chk("lw_addr_alu", addr_sel, 1);
        chk("lw_beat0", beat_idx, 0);
        nxt(); mem_complete = 1'b0; #1;
        chk("lw_wb_write_rd", write_rd, 1);
        chk("lw_wb_retire", retire, 1);
        chk("lw_wb_rd_sel", rd_sel, 1);
        nxt(); #1;
        chk("lw_back_fetch", mem_read, 1);
        chk("lw_no_retire", retire, 0);

        // Misaligned SW: two beats, each completing on its 4th cycle.
        nxt(); opcode = STORE; beats_needed = 2'd2; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        n_mw = 0; n_ret = 0;
        for (int i = 0; i < 8; i++) begin
            nxt(); mem_complete = (i == 3 || i == 7); #1;
            n_mw += int'(mem_write);
            n_ret += int'(retire);
            chk($sformatf("sw_beat_idx_%0d", i), beat_idx, (i >= 4) ? 1 : 0);
        end
        nxt(); mem_complete = 1'b0; #1;
        chk("sw_mem_write_cycles", n_mw, 8);
        chk("sw_retire_count", n_ret, 1);
        chk("sw_back_fetch", mem_read, 1);
        chk("sw_write_dropped", mem_write, 0);

        // LW with memory that never answers.
        nxt(); opcode = LOAD; beats_needed = 2'd1; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        for (int i = 1; i <= 5; i++) begin
            nxt(); #1;
            chk($sformatf("tmo_pulse_%0d", i), bus_timeout, (i == 5) ? 1 : 0);
            chk($sformatf("tmo_strobe_%0d", i), mem_read, (i == 5) ? 0 : 1);
        end
        chk("tmo_write_pc_ex", write_pc_ex, 1);
        chk("tmo_retire", retire, 0);
        nxt(); #1;
        chk("tmo_back_fetch", {mem_read, addr_sel}, {1'b1, 2'd0});
        chk("tmo_pulse_end", bus_timeout, 0);

        // Halt request during a 2-beat load.
        nxt(); opcode = LOAD; beats_needed = 2'd2; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        nxt(); halt_req = 1'b1; #1;
        chk("hlt_beat0_wait", {mem_read, beat_idx}, 2'b10);
        nxt(); mem_complete = 1'b1; #1;
        chk("hlt_not_yet", halted, 0);
        nxt(); mem_complete = 1'b1; #1;
        chk("hlt_beat1", {mem_read, beat_idx}, 2'b11);
        nxt(); mem_complete = 1'b0; #1;
        chk("hlt_wb_write_rd", write_rd, 1);
        chk("hlt_wb_retire", retire, 1);
        nxt(); halt_req = 1'b0; #1;
        chk("hlt_halted", halted, 1);
        chk("hlt_no_strobe", mem_read, 0);

        // Abstract memory read of four words.
        nxt(); abstract = 1'b1; opcode = ABS_MEM; f3 = 3'b000; abs_count = 4'd3; #1;
        n_wr = 0; n_inc = 0; n_done = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            nxt(); abstract = 1'b0; mem_complete = (i % 2 == 1); #1;
            n_wr += int'(abstract_write);
            n_inc += int'(abs_addr_inc);
            n_done += int'(abstract_done);
            seen = halted;
        end
        mem_complete = 1'b0;
        chk("abs_back_halted", seen, 1);
        chk("abs_write_pulses", n_wr, 4);
        chk("abs_inc_pulses", n_inc, 4);
        chk("abs_done_pulses", n_done, 1);

        // Resume, then WFI: halt, resume, interrupt.
        nxt(); resume_req = 1'b1; #1;
        nxt(); resume_req = 1'b0; #1;
        chk("res_fetch", {halted, mem_read}, 2'b01);
        nxt(); opcode = SYSTEM; f3 = 3'b000; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        nxt(); #1;
        chk("wfi_idle", {retire, mem_read, halted}, 0);
        nxt(); halt_req = 1'b1; #1;
        chk("wfi_halt_no_retire", retire, 0);
        nxt(); halt_req = 1'b0; #1;
        chk("wfi_halted", halted, 1);
        nxt(); resume_req = 1'b1; #1;
        nxt(); resume_req = 1'b0; #1;
        chk("wfi_refetch", mem_read, 1);
        nxt(); mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        nxt(); #1;
        chk("wfi_wait_no_retire", retire, 0);
        nxt(); interrupt_pending = 1'b1; #1;
        chk("wfi_irq_retire", {retire, write_pc}, 2'b11);
        nxt(); interrupt_pending = 1'b0; #1;
        chk("wfi_irq_fetch", mem_read, 1);

        // Access needing more beats than the bus supports traps.
        nxt(); opcode = LOAD; beats_needed = 2'd3; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        nxt(); #1;
        chk("mis_trap", {write_pc_ex, retire}, 2'b10);
        nxt(); beats_needed = 2'd1; #1;
        chk("mis_fetch", {mem_read, addr_sel}, {1'b1, 2'd0});

        // Exception in EXEC suppresses writeback; halt taken at the redirect.
        nxt(); opcode = OP; mem_complete = 1'b1; #1;
        nxt(); mem_complete = 1'b0; #1;
        nxt(); exception = 1'b1; halt_req = 1'b1; #1;
        chk("exc_pc_ex", write_pc_ex, 1);
        chk("exc_kill", {write_rd, write_pc, retire}, 0);
        nxt(); exception = 1'b0; halt_req = 1'b0; #1;
        chk("exc_halted", halted, 1);

        // Abstract and resume together: abstract register read wins.
        nxt(); abstract = 1'b1; resume_req = 1'b1; opcode = ABS_REG; f3 = 3'b000; #1;
        nxt(); abstract = 1'b0; resume_req = 1'b0; #1;
        chk("areg_write_done", {abstract_write, abstract_done, halted}, 3'b110);
        nxt(); #1;
        chk("areg_halted", {halted, mem_read}, 2'b10);

`ifdef CONTROL_SEQ__SINGLE_STEP_EN
        // Single step over one ADDI.
        nxt(); step = 1'b1; resume_req = 1'b1; #1;
        nxt(); resume_req = 1'b0; opcode = OPIMM; mem_complete = 1'b1; #1;
        chk("step_fetch", write_ir, 1);
        nxt(); mem_complete = 1'b0; #1;
        nxt(); #1;
        chk("step_retire", {retire, write_rd}, 2'b11);
        nxt(); #1;
        chk("step_halted", {halted, retire}, 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
